// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: start/done handshake between the exponentiation controller and a Montgomery multiplier
//   mm_x, mm_y : multiplier operands (controller -> multiplier), held stable while mm_start is high
//   mm_start   : operation request level (controller -> multiplier)
//   mm_z       : multiplier result x*y*R^-1 mod m (multiplier -> controller)
//   mm_done    : one-cycle completion pulse (multiplier -> controller)
interface mod_exp_ctrl_if #(
    parameter int W = 192
);
    logic [W-1:0] mm_x;
    logic [W-1:0] mm_y;
    logic [W-1:0] mm_z;
    logic         mm_start;
    logic         mm_done;
    modport master(output mm_x, mm_y, mm_start, input mm_z, mm_done);
    modport slave(input mm_x, mm_y, mm_start, output mm_z, mm_done);
endinterface

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: base^exp mod m by left-to-right square-and-multiply over an external Montgomery multiplier
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle request, only honoured while idle
//   base, exp: operands, latched on start (base < m is the caller's obligation)
//   busy     : high from the cycle after start until the operation finishes (low during done)
//   done     : one-cycle pulse, result valid in the same cycle
//   result   : base^exp mod m, held until the next done
//   mm       : multiplier handshake (master side)
module mod_exp_ctrl #(
    parameter int           W  = 192,
    parameter int           EW = 192,
    parameter logic [W-1:0] R2 = 192'h000000000000000100000000000000020000000000000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     base,
    input  logic [EW-1:0]    exp,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    mod_exp_ctrl_if.master   mm
);
    localparam int CW = $clog2(EW + 1);

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, GAP, DONE} state_t;
    typedef enum logic [1:0] {OP_TOM, OP_SQ, OP_MUL, OP_FROM} op_t;

    state_t        state, state_n;
    op_t           op, op_n;
    logic [W-1:0]  b_reg, b_n;
    logic [EW-1:0] e_reg, e_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  acc, acc_n;
    logic [W-1:0]  bm, bm_n;
    logic [W-1:0]  result_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= OP_TOM;
            b_reg  <= '0;
            e_reg  <= '0;
            cnt    <= '0;
            acc    <= '0;
            bm     <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            op     <= op_n;
            b_reg  <= b_n;
            e_reg  <= e_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            bm     <= bm_n;
            result <= result_n;
        end
    end

    assign busy        = state inside {SCAN, ISSUE, GAP};
    assign done        = state == DONE;
    assign mm.mm_start = state == ISSUE;
    assign mm.mm_x     = state != ISSUE ? '0 : op == OP_TOM ? b_reg : acc;
    assign mm.mm_y     = state != ISSUE ? '0 : op == OP_TOM ? R2 : op == OP_SQ ? acc : op == OP_MUL ? bm : W'(1);

    // cnt counts scanned leading zeros in SCAN, then the exponent bits still to consume
    always_comb begin
        state_n  = state;
        op_n     = op;
        b_n      = b_reg;
        e_n      = e_reg;
        cnt_n    = cnt;
        acc_n    = acc;
        bm_n     = bm;
        result_n = result;
        unique case (state)
            IDLE: if (start) begin
                b_n     = base;
                e_n     = exp;
                cnt_n   = '0;
                state_n = SCAN;
            end
            SCAN: if (e_reg[EW-1]) begin
                cnt_n   = CW'(EW - 1) - cnt;
                op_n    = OP_TOM;
                state_n = ISSUE;
            end else if (cnt == CW'(EW - 1)) begin
                result_n = W'(1);
                state_n  = DONE;
            end else begin
                e_n   = e_reg << 1;
                cnt_n = cnt + 1'b1;
            end
            ISSUE: if (mm.mm_done) begin
                state_n  = GAP;
                acc_n    = op == OP_FROM ? acc : mm.mm_z;
                bm_n     = op == OP_TOM ? mm.mm_z : bm;
                result_n = op == OP_FROM ? mm.mm_z : result;
            end
            // the gap cycle decides the next op; after a square the MSB already holds the freshly shifted bit
            GAP: begin
                state_n = op == OP_FROM ? DONE : ISSUE;
                if (op == OP_SQ && e_reg[EW-1]) op_n = OP_MUL;
                else if (op != OP_FROM && cnt == '0) op_n = OP_FROM;
                else if (op != OP_FROM) begin
                    op_n  = OP_SQ;
                    e_n   = e_reg << 1;
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: randomized scoreboard bench for mod_exp_ctrl with a behavioural Montgomery multiplier
module tb_mod_exp_ctrl;
    localparam int W  = 192;
    localparam int EW = 192;
    localparam logic [W-1:0] M  = 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF;
    localparam logic [W-1:0] R2 = 192'h000000000000000100000000000000020000000000000001;

    logic          clk, rst, start, busy, done, inj, mdone, rst_q;
    logic [W-1:0]  base, result, mz;
    logic [EW-1:0] expo;
    logic [W-1:0]  px, py;
    bit            p_start, p_done, p_gap;
    int            cyc, lat, mk, vectors, miscompares;
    string         seq;

    logic [W-1:0]  exp_res[$];
    logic [W-1:0]  exp_base[$];
    int            exp_cyc[$];
    string         exp_seq[$];

    mod_exp_ctrl_if #(.W(W)) mif();

    mod_exp_ctrl #(.W(W), .EW(EW), .R2(R2)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(expo),
        .busy(busy), .done(done), .result(result), .mm(mif.master)
    );

    assign mif.mm_z    = mz;
    assign mif.mm_done = mdone | inj;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // radix-2 Montgomery product a*b*2^-W mod M, the attached multiplier's behaviour
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) r = r + {2'b0, b};
            if (r[0]) r = r + {2'b0, M};
            r = r >> 1;
        end
        if (r >= {2'b0, M}) r = r - {2'b0, M};
        return r[W-1:0];
    endfunction

    // reference: plain modular exponentiation with double-width products
    function automatic logic [W-1:0] powmod(input logic [W-1:0] b, input logic [EW-1:0] e);
        logic [2*W-1:0] t;
        logic [W-1:0]   r;
        r = W'(1);
        for (int i = EW - 1; i >= 0; i--) begin
            t = ({{W{1'b0}}, r} * {{W{1'b0}}, r}) % {{W{1'b0}}, M};
            r = t[W-1:0];
            if (e[i]) begin
                t = ({{W{1'b0}}, r} * {{W{1'b0}}, b}) % {{W{1'b0}}, M};
                r = t[W-1:0];
            end
        end
        return r;
    endfunction

    function automatic int bitlen(input logic [EW-1:0] e);
        int k;
        k = 0;
        for (int i = 0; i < EW; i++) if (e[i]) k = i + 1;
        return k;
    endfunction

    function automatic string seq_of(input logic [EW-1:0] e);
        string s;
        int    k;
        k = bitlen(e);
        if (k == 0) return "";
        s = "T";
        for (int i = k - 2; i >= 0; i--) begin
            s = {s, "S"};
            if (e[i]) s = {s, "M"};
        end
        return {s, "F"};
    endfunction

    function automatic int lat_of(input logic [EW-1:0] e);
        int k, nops;
        k = bitlen(e);
        if (k == 0) return EW + 1;
        nops = 2 + (k - 1) + ($countones(e) - 1);
        return (EW - k) + 2 + nops * (lat + 2);
    endfunction

    function automatic string cls(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] b);
        if (x == b && y == R2) return "T";
        if (y == W'(1)) return "F";
        if (x == y) return "S";
        return "M";
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r >= M ? r - M : r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_q <= rst;

    always @(posedge clk) begin
        if (rst || mdone) begin
            mdone <= 1'b0;
            mk    <= 0;
        end else if (mif.mm_start) begin
            if (mk + 1 >= lat) begin
                mdone <= 1'b1;
                mz    <= mont(mif.mm_x, mif.mm_y);
            end else mk <= mk + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_q) begin
            seq     = "";
            p_start = 0;
            p_done  = 0;
            p_gap   = 0;
        end else begin
            chk("done_expected", W'(done && exp_res.size() == 0), '0);
            chk("busy_done_overlap", W'(busy && done), '0);
            if (p_start && !p_done) begin
                chk("mm_start_hold", W'(mif.mm_start), W'(1));
                chk("mm_x_hold", mif.mm_x, px);
                chk("mm_y_hold", mif.mm_y, py);
            end
            if (p_start && p_done) chk("mm_gap", W'(mif.mm_start), '0);
            if (p_gap && busy) chk("mm_restart", W'(mif.mm_start), W'(1));
            if (mif.mm_start && !p_start)
                seq = {seq, cls(mif.mm_x, mif.mm_y, exp_base.size() != 0 ? exp_base[0] : '0)};
            if (done && exp_res.size() != 0) begin
                chk("result", result, exp_res[0]);
                chk("done_cycle", W'(cyc), W'(exp_cyc[0]));
                vectors++;
                if (seq != exp_seq[0]) begin
                    miscompares++;
                    $display("FAIL op_seq: got '%s' want '%s'", seq, exp_seq[0]);
                end
                void'(exp_res.pop_front());
                void'(exp_base.pop_front());
                void'(exp_cyc.pop_front());
                void'(exp_seq.pop_front());
            end
            if (done) seq = "";
            p_gap   = p_start && p_done;
            p_start = mif.mm_start;
            p_done  = mif.mm_done;
            px      = mif.mm_x;
            py      = mif.mm_y;
        end
    end

    task automatic flush();
        exp_res.delete();
        exp_base.delete();
        exp_cyc.delete();
        exp_seq.delete();
    endtask

    task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e, input int poke, input int inj_at);
        @(negedge clk);
        exp_res.push_back(powmod(b, e));
        exp_base.push_back(b);
        exp_cyc.push_back(cyc + lat_of(e));
        exp_seq.push_back(seq_of(e));
        base  = b;
        expo  = e;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 1; i < 6000 && exp_res.size() != 0; i++) begin
            start = i == poke;
            inj   = i == inj_at;
            if (start) begin
                base = ~b;
                expo = e ^ EW'(3);
            end
            @(negedge clk);
        end
        start = 0;
        inj   = 0;
        if (exp_res.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: done not seen for exp %h", e);
            flush();
            rst = 1;
            repeat (2) @(negedge clk);
            rst = 0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic directed();
        run(W'(5), EW'(0), 0, 0);
        run(W'(8'hF7), EW'(1), 0, 0);
        run(W'(2), EW'(16), 0, 0);
        run(W'(3), EW'(5), 0, 0);
        run(M - W'(1), EW'(2), 0, 0);
        run(R2, EW'(1), 0, 0);
    endtask

    initial begin
        int n;
        bit prev;
        cyc = 0; vectors = 0; miscompares = 0; lat = 1; mk = 0;
        rst = 1; start = 0; inj = 0; base = '0; expo = '0; mdone = 0; mz = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result", result, '0);
        chk("rst_mm_start", W'(mif.mm_start), '0);
        chk("rst_mm_x", mif.mm_x, '0);
        chk("rst_mm_y", mif.mm_y, '0);
        rst = 0;

        lat = 1;
        directed();
        for (int i = 0; i < 5; i++) run(rnd(), EW'(rnd() >> $urandom_range(0, EW - 1)), 0, 0);
        lat = 7;
        directed();
        for (int i = 0; i < 4; i++) run(rnd(), EW'(rnd() >> $urandom_range(0, EW - 1)), 0, 0);
        lat = $urandom_range(2, 4);
        for (int i = 0; i < 3; i++) run(rnd(), EW'(rnd() >> $urandom_range(100, EW - 1)), 0, 0);

        lat = 7;
        run(W'(3), EW'(5), 4, 0);
        run(W'(9), EW'(8'hA7), 0, 20);

        @(negedge clk);
        exp_res.push_back('0);
        exp_base.push_back(W'(11));
        exp_cyc.push_back(0);
        exp_seq.push_back("");
        base  = W'(11);
        expo  = EW'(15);
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        prev = 0;
        for (int i = 0; i < 2000 && n < 3; i++) begin
            @(negedge clk);
            if (mif.mm_start && !prev) n++;
            prev = mif.mm_start;
        end
        chk("third_op_reached", W'(n), W'(3));
        rst = 1;
        flush();
        @(negedge clk);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_mm_start", W'(mif.mm_start), '0);
        chk("midrst_result", result, '0);
        rst = 0;
        inj = 1;
        @(negedge clk);
        inj = 0;
        @(negedge clk);
        chk("stale_done_busy", W'(busy), '0);
        chk("stale_done_result", result, '0);
        chk("stale_done_mm_start", W'(mif.mm_start), '0);
        run(W'(3), EW'(5), 0, 0);
        chk("post_rst_result", result, W'(8'hF3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
